// File: rtl/atm_controller_mc.sv
// Multi-account ATM session controller: card/PIN sequencing, timeout, and
// balance/withdraw/deposit/mini-statement transactions with per-account history.
module atm_controller_mc #(
    parameter int BAL_W         = 16,
    parameter int NUM_ACCTS     = 4,
    parameter int INIT_BAL      = 1000,
    parameter int MAX_PIN_TRIES = 3,
    parameter int DAILY_LIMIT   = 500,
    parameter int HIST_DEPTH    = 4,
    parameter int TIMEOUT_CYC   = 1000,
    localparam int ACCT_W       = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               card_inserted,
    input  logic [ACCT_W-1:0]  acct_id,
    input  logic               pin_entered,
    input  logic               pin_ok,
    input  logic               txn_valid,
    input  logic [1:0]         txn_type,
    input  logic [BAL_W-1:0]   amount,
    input  logic               cancel,
    input  logic               day_rollover,
    output logic               txn_ready,
    output logic               txn_done,
    output logic [1:0]         txn_status,
    output logic [BAL_W-1:0]   old_balance,
    output logic [BAL_W-1:0]   new_balance,
    output logic               hist_valid,
    output logic [BAL_W+1:0]   hist_data,
    output logic               hist_last,
    output logic               card_eject,
    output logic               card_captured,
    output logic [1:0]         pin_tries
);

    localparam int HIST_W = $clog2(HIST_DEPTH);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] T_BAL = 2'd0, T_WD = 2'd1, T_DEP = 2'd2, T_STMT = 2'd3;
    localparam logic [1:0] ST_OK = 2'd0, ST_NSF = 2'd1, ST_LIM = 2'd2, ST_OVF = 2'd3;
    localparam logic [1:0]        MAX_T      = 2'(MAX_PIN_TRIES);
    localparam logic [BAL_W:0]    LIMIT      = (BAL_W+1)'(DAILY_LIMIT);
    localparam logic [HIST_W:0]   HIST_FULL  = (HIST_W+1)'(HIST_DEPTH);
    localparam logic [HIST_W:0]   ONE_ENTRY  = (HIST_W+1)'(1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PIN_WAIT, S_MENU, S_EXEC, S_DONE, S_STMT, S_EJECT, S_CAPTURE
    } state_t;

    state_t              state, state_n;
    logic [ACCT_W-1:0]   acct_q;
    logic [1:0]          type_q;
    logic [BAL_W-1:0]    amt_q;
    logic [1:0]          tries;
    logic [TO_W-1:0]     to_cnt;
    logic                to_hit;
    logic [BAL_W-1:0]    bal       [NUM_ACCTS];
    logic [BAL_W-1:0]    daily     [NUM_ACCTS];
    logic [HIST_W-1:0]   hptr      [NUM_ACCTS];
    logic [HIST_W:0]     hcnt      [NUM_ACCTS];
    logic [BAL_W+1:0]    hist_mem  [NUM_ACCTS][HIST_DEPTH];
    logic [HIST_W-1:0]   rd_ptr;
    logic [HIST_W:0]     rem;
    logic [1:0]          exec_status;
    logic [BAL_W-1:0]    exec_bal;

    // Failure checks in priority order; sums carry one extra bit so overflow is visible.
    function automatic logic [1:0] txn_check(input logic [1:0] t,
                                             input logic [BAL_W-1:0] b,
                                             input logic [BAL_W-1:0] d,
                                             input logic [BAL_W-1:0] a);
        logic [BAL_W:0] dsum;
        logic [BAL_W:0] bsum;
        dsum = {1'b0, d} + {1'b0, a};
        bsum = {1'b0, b} + {1'b0, a};
        txn_check = ST_OK;
        if (t == T_WD) begin
            if (a > b)
                txn_check = ST_NSF;
            else if (dsum > LIMIT)
                txn_check = ST_LIM;
        end else if (t == T_DEP && bsum[BAL_W]) begin
            txn_check = ST_OVF;
        end
    endfunction

    always_comb begin
        exec_status = txn_check(type_q, bal[acct_q], daily[acct_q], amt_q);
        exec_bal    = bal[acct_q];
        if (exec_status == ST_OK) begin
            if (type_q == T_WD)
                exec_bal = bal[acct_q] - amt_q;
            else if (type_q == T_DEP)
                exec_bal = bal[acct_q] + amt_q;
        end
    end

    assign to_hit    = (to_cnt == TO_LAST);
    assign pin_tries = tries;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n       = state;
        txn_ready     = 1'b0;
        txn_done      = 1'b0;
        hist_valid    = 1'b0;
        hist_data     = '0;
        hist_last     = 1'b0;
        card_eject    = 1'b0;
        card_captured = 1'b0;
        case (state)
            S_IDLE:     if (card_inserted) state_n = S_PIN_WAIT;
            S_PIN_WAIT: begin
                if (!card_inserted)
                    state_n = S_IDLE;
                else if (pin_entered) begin
                    if (pin_ok)
                        state_n = S_MENU;
                    else if (tries == MAX_T - 2'd1)
                        state_n = S_CAPTURE;
                end else if (to_hit)
                    state_n = S_EJECT;
            end
            S_MENU: begin
                txn_ready = 1'b1;
                if (!card_inserted)
                    state_n = S_IDLE;
                else if (txn_valid)
                    state_n = S_EXEC;
                else if (cancel || to_hit)
                    state_n = S_EJECT;
            end
            S_EXEC:
                state_n = (type_q == T_STMT && hcnt[acct_q] != '0) ? S_STMT : S_DONE;
            S_STMT: begin
                hist_valid = 1'b1;
                hist_data  = hist_mem[acct_q][rd_ptr];
                hist_last  = (rem == ONE_ENTRY);
                if (rem == ONE_ENTRY)
                    state_n = S_DONE;
            end
            S_DONE: begin
                txn_done = 1'b1;
                state_n  = card_inserted ? S_MENU : S_IDLE;
            end
            S_EJECT: begin
                card_eject = 1'b1;
                if (!card_inserted) state_n = S_IDLE;
            end
            S_CAPTURE: begin
                card_captured = 1'b1;
                if (!card_inserted) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acct_q      <= '0;
            type_q      <= '0;
            amt_q       <= '0;
            tries       <= '0;
            to_cnt      <= '0;
            rd_ptr      <= '0;
            rem         <= '0;
            txn_status  <= '0;
            old_balance <= '0;
            new_balance <= '0;
            for (int a = 0; a < NUM_ACCTS; a++) begin
                bal[a]   <= BAL_W'(INIT_BAL);
                daily[a] <= '0;
                hptr[a]  <= '0;
                hcnt[a]  <= '0;
                for (int h = 0; h < HIST_DEPTH; h++)
                    hist_mem[a][h] <= '0;
            end
        end else begin
            if (day_rollover)
                for (int a = 0; a < NUM_ACCTS; a++)
                    daily[a] <= '0;
            // Idle timer runs only while waiting on the user with no activity.
            if ((state == S_PIN_WAIT || state == S_MENU) && state_n == state &&
                !pin_entered && !txn_valid)
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
            case (state)
                S_IDLE: if (card_inserted) begin
                    acct_q <= acct_id;
                    tries  <= '0;
                end
                S_PIN_WAIT: if (card_inserted && pin_entered)
                    tries <= pin_ok ? 2'd0 : tries + 2'd1;
                S_MENU: if (card_inserted && txn_valid) begin
                    type_q <= txn_type;
                    amt_q  <= amount;
                end
                S_EXEC: begin
                    txn_status  <= exec_status;
                    old_balance <= bal[acct_q];
                    new_balance <= exec_bal;
                    rd_ptr      <= hptr[acct_q] - 1'b1;
                    rem         <= hcnt[acct_q];
                    if (exec_status == ST_OK && (type_q == T_WD || type_q == T_DEP)) begin
                        bal[acct_q]                   <= exec_bal;
                        hist_mem[acct_q][hptr[acct_q]] <= {type_q, amt_q};
                        hptr[acct_q]                  <= hptr[acct_q] + 1'b1;
                        if (hcnt[acct_q] != HIST_FULL)
                            hcnt[acct_q] <= hcnt[acct_q] + 1'b1;
                        // A coinciding rollover clears the total before this withdrawal lands.
                        if (type_q == T_WD)
                            daily[acct_q] <= day_rollover ? amt_q : daily[acct_q] + amt_q;
                    end
                end
                S_STMT: begin
                    rd_ptr <= rd_ptr - 1'b1;
                    rem    <= rem - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_controller_mc.sv
// Directed bench for atm_controller_mc: sessions, PIN capture, limits, history, timeout, reset.
module tb_atm_controller_mc;

    localparam int TIMEOUT_CYC = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        card_inserted = 1'b0;
    logic [1:0]  acct_id = '0;
    logic        pin_entered = 1'b0;
    logic        pin_ok = 1'b0;
    logic        txn_valid = 1'b0;
    logic [1:0]  txn_type = '0;
    logic [15:0] amount = '0;
    logic        cancel = 1'b0;
    logic        day_rollover = 1'b0;
    logic        txn_ready, txn_done, hist_valid, hist_last, card_eject, card_captured;
    logic [1:0]  txn_status, pin_tries;
    logic [15:0] old_balance, new_balance;
    logic [17:0] hist_data;

    int checks = 0;
    int failures = 0;

    atm_controller_mc dut (
        .clk(clk), .reset(reset), .card_inserted(card_inserted), .acct_id(acct_id),
        .pin_entered(pin_entered), .pin_ok(pin_ok), .txn_valid(txn_valid),
        .txn_type(txn_type), .amount(amount), .cancel(cancel), .day_rollover(day_rollover),
        .txn_ready(txn_ready), .txn_done(txn_done), .txn_status(txn_status),
        .old_balance(old_balance), .new_balance(new_balance), .hist_valid(hist_valid),
        .hist_data(hist_data), .hist_last(hist_last), .card_eject(card_eject),
        .card_captured(card_captured), .pin_tries(pin_tries)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic insert_card(input logic [1:0] a);
        card_inserted = 1'b1;
        acct_id = a;
        tick(1);
    endtask

    task automatic enter_pin(input logic ok);
        pin_entered = 1'b1;
        pin_ok = ok;
        tick(1);
        pin_entered = 1'b0;
        pin_ok = 1'b0;
    endtask

    task automatic end_session();
        cancel = 1'b1;
        tick(1);
        cancel = 1'b0;
        card_inserted = 1'b0;
        tick(1);
    endtask

    // Issues one transaction from MENU; returns what was seen in EXEC and DONE.
    task automatic run_txn(input logic [1:0] t, input logic [15:0] amt, input logic roll,
                           input logic canc, output logic early, output logic done,
                           output logic [1:0] st, output logic [15:0] ob, output logic [15:0] nb);
        txn_valid = 1'b1; txn_type = t; amount = amt; cancel = canc;
        tick(1);
        txn_valid = 1'b0; cancel = 1'b0; day_rollover = roll;
        early = txn_done;
        tick(1);
        day_rollover = 1'b0;
        done = txn_done; st = txn_status; ob = old_balance; nb = new_balance;
        tick(1);
    endtask

    task automatic test_reset();
        logic [59:0] all_out;
        reset = 1'b0;
        tick(2);
        all_out = {txn_ready, txn_done, txn_status, old_balance, new_balance, hist_valid,
                   hist_data, hist_last, card_eject, card_captured, pin_tries};
        checks++; if (all_out !== 60'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
        reset = 1'b1;
        tick(1);
        checks++; if (txn_ready !== 1'b0 || card_eject !== 1'b0) begin failures++; $display("FAIL reset_idle ready=%b eject=%b exp=0/0", txn_ready, card_eject); end
    endtask

    task automatic test_withdraw_basic();
        logic e, d; logic [1:0] st; logic [15:0] ob, nb;
        insert_card(2'd2);
        checks++; if (txn_ready !== 1'b0 || pin_tries !== 2'd0) begin failures++; $display("FAIL pinwait_state ready=%b tries=%0d exp=0/0", txn_ready, pin_tries); end
        enter_pin(1'b1);
        checks++; if (txn_ready !== 1'b1) begin failures++; $display("FAIL menu_ready got=%b exp=1", txn_ready); end
        run_txn(2'd1, 16'd200, 1'b0, 1'b0, e, d, st, ob, nb);
        checks++; if (e !== 1'b0 || d !== 1'b1) begin failures++; $display("FAIL wd200_latency exec=%b done=%b exp=0/1", e, d); end
        checks++; if (st !== 2'd0 || ob !== 16'd1000 || nb !== 16'd800) begin failures++; $display("FAIL wd200_result st=%0d old=%0d new=%0d exp=0/1000/800", st, ob, nb); end
        checks++; if (txn_done !== 1'b0 || old_balance !== 16'd1000 || new_balance !== 16'd800) begin failures++; $display("FAIL wd200_hold done=%b old=%0d new=%0d exp=0/1000/800", txn_done, old_balance, new_balance); end
        cancel = 1'b1;
        tick(1);
        cancel = 1'b0;
        checks++; if (card_eject !== 1'b1) begin failures++; $display("FAIL cancel_eject got=%b exp=1", card_eject); end
        tick(3);
        checks++; if (card_eject !== 1'b1 || txn_ready !== 1'b0) begin failures++; $display("FAIL eject_held eject=%b ready=%b exp=1/0", card_eject, txn_ready); end
        card_inserted = 1'b0;
        tick(1);
        checks++; if (card_eject !== 1'b0) begin failures++; $display("FAIL eject_release got=%b exp=0", card_eject); end
    endtask

    task automatic test_pin_capture();
        insert_card(2'd0);
        enter_pin(1'b0);
        checks++; if (pin_tries !== 2'd1 || card_captured !== 1'b0) begin failures++; $display("FAIL bad_pin1 tries=%0d cap=%b exp=1/0", pin_tries, card_captured); end
        enter_pin(1'b0);
        checks++; if (pin_tries !== 2'd2 || card_captured !== 1'b0) begin failures++; $display("FAIL bad_pin2 tries=%0d cap=%b exp=2/0", pin_tries, card_captured); end
        enter_pin(1'b0);
        checks++; if (card_captured !== 1'b1 || card_eject !== 1'b0) begin failures++; $display("FAIL bad_pin3 cap=%b eject=%b exp=1/0", card_captured, card_eject); end
        tick(3);
        checks++; if (card_captured !== 1'b1 || card_eject !== 1'b0) begin failures++; $display("FAIL capture_held cap=%b eject=%b exp=1/0", card_captured, card_eject); end
        card_inserted = 1'b0;
        tick(1);
        checks++; if (card_captured !== 1'b0) begin failures++; $display("FAIL capture_release got=%b exp=0", card_captured); end
        insert_card(2'd0);
        checks++; if (pin_tries !== 2'd0) begin failures++; $display("FAIL tries_cleared got=%0d exp=0", pin_tries); end
        card_inserted = 1'b0;
        tick(1);
        checks++; if (card_eject !== 1'b0 || txn_ready !== 1'b0) begin failures++; $display("FAIL pinwait_removal eject=%b ready=%b exp=0/0", card_eject, txn_ready); end
    endtask

    task automatic test_daily_limit();
        logic e, d; logic [1:0] st; logic [15:0] ob, nb;
        insert_card(2'd0);
        enter_pin(1'b1);
        run_txn(2'd1, 16'd300, 1'b0, 1'b0, e, d, st, ob, nb);
        checks++; if (st !== 2'd0 || nb !== 16'd700) begin failures++; $display("FAIL daily_wd1 st=%0d new=%0d exp=0/700", st, nb); end
        run_txn(2'd1, 16'd300, 1'b0, 1'b0, e, d, st, ob, nb);
        checks++; if (st !== 2'd2 || ob !== 16'd700 || nb !== 16'd700) begin failures++; $display("FAIL daily_wd2 st=%0d old=%0d new=%0d exp=2/700/700", st, ob, nb); end
        day_rollover = 1'b1;
        tick(1);
        day_rollover = 1'b0;
        run_txn(2'd1, 16'd300, 1'b0, 1'b0, e, d, st, ob, nb);
        checks++; if (st !== 2'd0 || nb !== 16'd400) begin failures++; $display("FAIL daily_after_roll st=%0d new=%0d exp=0/400", st, nb); end
        run_txn(2'd1, 16'd200, 1'b1, 1'b0, e, d, st, ob, nb);
        checks++; if (st !== 2'd0 || nb !== 16'd200) begin failures++; $display("FAIL daily_roll_exec st=%0d new=%0d exp=0/200", st, nb); end
        run_txn(2'd2, 16'd1000, 1'b0, 1'b0, e, d, st, ob, nb);
        checks++; if (st !== 2'd0 || nb !== 16'd1200) begin failures++; $display("FAIL daily_dep st=%0d new=%0d exp=0/1200", st, nb); end
        run_txn(2'd1, 16'd301, 1'b0, 1'b0, e, d, st, ob, nb);
        checks++; if (st !== 2'd2 || nb !== 16'd1200) begin failures++; $display("FAIL daily_total_kept st=%0d new=%0d exp=2/1200", st, nb); end
        run_txn(2'd1, 16'd300, 1'b0, 1'b0, e, d, st, ob, nb);
        checks++; if (st !== 2'd0 || nb !== 16'd900) begin failures++; $display("FAIL daily_at_limit st=%0d new=%0d exp=0/900", st, nb); end
        end_session();
    endtask

    task automatic test_funds_overflow();
        logic e, d; logic [1:0] st; logic [15:0] ob, nb;
        insert_card(2'd3);
        enter_pin(1'b1);
        run_txn(2'd1, 16'd1200, 1'b0, 1'b0, e, d, st, ob, nb);
        checks++; if (st !== 2'd1 || ob !== 16'd1000 || nb !== 16'd1000) begin failures++; $display("FAIL nsf st=%0d old=%0d new=%0d exp=1/1000/1000", st, ob, nb); end
        run_txn(2'd2, 16'd65000, 1'b0, 1'b0, e, d, st, ob, nb);
        checks++; if (st !== 2'd3 || nb !== 16'd1000) begin failures++; $display("FAIL dep_overflow st=%0d new=%0d exp=3/1000", st, nb); end
        run_txn(2'd0, 16'd0, 1'b0, 1'b1, e, d, st, ob, nb);
        checks++; if (d !== 1'b1 || st !== 2'd0 || ob !== 16'd1000 || nb !== 16'd1000) begin failures++; $display("FAIL inquiry done=%b st=%0d old=%0d new=%0d exp=1/0/1000/1000", d, st, ob, nb); end
        checks++; if (txn_ready !== 1'b1 || card_eject !== 1'b0) begin failures++; $display("FAIL txn_over_cancel ready=%b eject=%b exp=1/0", txn_ready, card_eject); end
        run_txn(2'd2, 16'd0, 1'b0, 1'b0, e, d, st, ob, nb);
        checks++; if (st !== 2'd0 || nb !== 16'd1000) begin failures++; $display("FAIL dep_zero st=%0d new=%0d exp=0/1000", st, nb); end
        run_txn(2'd2, 16'd64535, 1'b0, 1'b0, e, d, st, ob, nb);
        checks++; if (st !== 2'd0 || nb !== 16'd65535) begin failures++; $display("FAIL dep_to_max st=%0d new=%0d exp=0/65535", st, nb); end
        end_session();
    endtask

    task automatic test_mini_statement();
        logic e, d; logic [1:0] st; logic [15:0] ob, nb;
        logic [17:0] beats [4];
        logic [17:0] exp_beat;
        logic [1:0]  done_st;
        int nbeats, done_at, lastpos;
        insert_card(2'd1);
        enter_pin(1'b1);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1)
                for (int k = 1; k <= 6; k++)
                    run_txn(2'd2, 16'(k), 1'b0, 1'b0, e, d, st, ob, nb);
            if (pass == 1) begin
                checks++; if (nb !== 16'd1021) begin failures++; $display("FAIL six_deposits new=%0d exp=1021", nb); end
            end
            txn_valid = 1'b1; txn_type = 2'd3; amount = '0;
            tick(1);
            txn_valid = 1'b0;
            nbeats = 0; done_at = -1; lastpos = -1; done_st = 2'd3;
            for (int c = 0; c < 12 && done_at < 0; c++) begin
                if (hist_valid) begin
                    if (nbeats < 4) beats[nbeats] = hist_data;
                    if (hist_last) lastpos = nbeats;
                    nbeats++;
                end
                if (txn_done) begin done_at = c; done_st = txn_status; end
                tick(1);
            end
            if (pass == 0) begin
                checks++; if (nbeats !== 0 || done_at !== 1) begin failures++; $display("FAIL stmt_empty beats=%0d done_at=%0d exp=0/1", nbeats, done_at); end
            end else begin
                checks++; if (nbeats !== 4 || lastpos !== 3) begin failures++; $display("FAIL stmt_beats beats=%0d last_at=%0d exp=4/3", nbeats, lastpos); end
                for (int i = 0; i < 4 && i < nbeats; i++) begin
                    exp_beat = {2'b10, 16'(6 - i)};
                    checks++; if (beats[i] !== exp_beat) begin failures++; $display("FAIL stmt_beat%0d got=%h exp=%h", i, beats[i], exp_beat); end
                end
                checks++; if (done_at !== 5 || done_st !== 2'd0) begin failures++; $display("FAIL stmt_done done_at=%0d st=%0d exp=5/0", done_at, done_st); end
            end
        end
        end_session();
    endtask

    task automatic test_timeout();
        int waited;
        insert_card(2'd0);
        enter_pin(1'b1);
        tick(TIMEOUT_CYC - 3);
        checks++; if (card_eject !== 1'b0 || txn_ready !== 1'b1) begin failures++; $display("FAIL timeout_early eject=%b ready=%b exp=0/1", card_eject, txn_ready); end
        waited = 0;
        while (card_eject !== 1'b1 && waited < 10) begin
            tick(1);
            waited++;
        end
        checks++; if (card_eject !== 1'b1) begin failures++; $display("FAIL timeout_eject eject=%b after %0d cycles exp=1", card_eject, waited); end
        checks++; if (pin_tries !== 2'd0) begin failures++; $display("FAIL timeout_tries got=%0d exp=0", pin_tries); end
        card_inserted = 1'b0;
        tick(1);
        insert_card(2'd0);
        enter_pin(1'b1);
        card_inserted = 1'b0;
        tick(2);
        checks++; if (card_eject !== 1'b0 || txn_ready !== 1'b0) begin failures++; $display("FAIL menu_removal eject=%b ready=%b exp=0/0", card_eject, txn_ready); end
    endtask

    task automatic test_reset_mid_exec();
        logic e, d; logic [1:0] st; logic [15:0] ob, nb;
        logic [59:0] all_out;
        insert_card(2'd2);
        enter_pin(1'b1);
        txn_valid = 1'b1; txn_type = 2'd1; amount = 16'd100;
        tick(1);
        txn_valid = 1'b0;
        reset = 1'b0;
        #1;
        all_out = {txn_ready, txn_done, txn_status, old_balance, new_balance, hist_valid,
                   hist_data, hist_last, card_eject, card_captured, pin_tries};
        checks++; if (all_out !== 60'd0) begin failures++; $display("FAIL midexec_reset_outputs got=%h exp=0", all_out); end
        card_inserted = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        insert_card(2'd2);
        enter_pin(1'b1);
        run_txn(2'd0, 16'd0, 1'b0, 1'b0, e, d, st, ob, nb);
        checks++; if (ob !== 16'd1000 || nb !== 16'd1000) begin failures++; $display("FAIL acct2_restored old=%0d new=%0d exp=1000/1000", ob, nb); end
        end_session();
        insert_card(2'd1);
        enter_pin(1'b1);
        run_txn(2'd0, 16'd0, 1'b0, 1'b0, e, d, st, ob, nb);
        checks++; if (ob !== 16'd1000) begin failures++; $display("FAIL acct1_restored old=%0d exp=1000", ob); end
        end_session();
    endtask

    initial begin
        test_reset();
        test_withdraw_basic();
        test_pin_capture();
        test_daily_limit();
        test_funds_overflow();
        test_mini_statement();
        test_timeout();
        test_reset_mid_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/atm_controller_mc.md
Name: atm_controller_mc

Overview:
- Parametrised multi-account successor to the single-account ATM controller.
- Handles card session sequencing, PIN retry limiting with card capture, and inactivity timeout.
- Executes balance, withdrawal, deposit and mini-statement transactions against NUM_ACCTS internal balance registers, with a per-account daily withdrawal limit and a per-account transaction history ring buffer.
- Sits between the card reader / keypad front end and the display / cash-dispenser back end.

Parameters:
- BAL_W, 16: balance and amount width (unsigned).
- NUM_ACCTS, 4: number of accounts; ACCT_W = clog2(NUM_ACCTS), minimum 1.
- INIT_BAL, 1000: reset value of every balance.
- MAX_PIN_TRIES, 3: consecutive bad PINs before card capture.
- DAILY_LIMIT, 500: maximum total withdrawal per account between day_rollover pulses.
- HIST_DEPTH, 4: history entries kept per account (power of 2, minimum 2).
- TIMEOUT_CYC, 1000: idle cycles allowed in PIN_WAIT or MENU before forced eject.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- card_inserted  in  1  card-present level from the reader.
- acct_id  in  ACCT_W  account of the inserted card; sampled on entry to PIN_WAIT.
- pin_entered  in  1  one-cycle strobe: PIN submitted.
- pin_ok  in  1  PIN comparison result; valid with pin_entered.
- txn_valid  in  1  transaction request.
- txn_type  in  2  request type: 00 balance, 01 withdraw, 10 deposit, 11 mini-statement.
- amount  in  BAL_W  transaction amount.
- cancel  in  1  user ends the session.
- day_rollover  in  1  strobe: clear all daily withdrawal totals.
- txn_ready  out  1  high in MENU only.
- txn_done  out  1  one-cycle completion pulse.
- txn_status  out  2  result: 00 ok, 01 insufficient funds, 10 daily limit exceeded, 11 deposit overflow.
- old_balance  out  BAL_W  balance before the transaction.
- new_balance  out  BAL_W  balance after the transaction.
- hist_valid  out  1  history beat valid.
- hist_data  out  BAL_W+2  history entry {type[1:0], amount}.
- hist_last  out  1  final history beat.
- card_eject  out  1  eject request.
- card_captured  out  1  card retained.
- pin_tries  out  2  current count of bad PINs.

Behaviour:
Reset
- All outputs 0. State IDLE.
- Balances = INIT_BAL; daily totals = 0; history counts = 0; tries = 0; timeout counter = 0.

States
- IDLE -> PIN_WAIT when card_inserted=1. Latch acct_id; tries = 0.
- PIN_WAIT, on pin_entered:
  - pin_ok=1 -> MENU; tries = 0.
  - pin_ok=0 -> tries+1; if tries reaches MAX_PIN_TRIES -> CAPTURE.
- MENU: txn_ready=1.
  - txn_valid=1 -> EXEC, latching type and amount.
  - cancel=1 -> EJECT. txn_valid takes priority over cancel in the same cycle.
- EXEC: one cycle. Checks and update as below.
  - Types 00/01/10 -> DONE.
  - Type 11 -> STMT.
- DONE: txn_done=1 for one cycle; old_balance, new_balance and txn_status held stable until the next txn_done. Returns to MENU.
- STMT: streams the latched account's history, newest first, one entry per cycle with hist_valid=1; hist_last=1 on the oldest entry. After the final beat, emits txn_done with status ok. With zero entries, txn_done fires immediately with hist_valid never asserted.
- EJECT: card_eject=1 until card_inserted=0, then IDLE.
- CAPTURE: card_captured=1 until card_inserted=0, then IDLE. card_eject stays 0.

Latency
- txn_done is asserted exactly 2 cycles after the txn_valid acceptance edge for types 00/01/10.

Checks, in priority order
- Withdraw:
  - amount > balance -> status 01.
  - Otherwise daily + amount > DAILY_LIMIT (computed at BAL_W+1 bits) -> status 10.
  - Otherwise balance -= amount; daily += amount.
- Deposit: balance + amount > 2^BAL_W-1 -> status 11; otherwise balance += amount.
- Balance inquiry: old_balance = new_balance = balance.
- Any failure leaves the balance unchanged and new_balance = old_balance.
- Successful types 01/10 write a history entry. Balance inquiries, mini-statements and failed transactions do not.
- Amount 0 succeeds, changes nothing, and is logged.

History
- Per-account ring buffer; write pointer wraps modulo HIST_DEPTH.
- Count saturates at HIST_DEPTH; when full, the oldest entry is overwritten.

Timeout
- Counter clears on entry to PIN_WAIT/MENU and on any pin_entered or txn_valid.
- Reaching TIMEOUT_CYC -> EJECT. Tries are not incremented by a timeout.

Card removal
- card_inserted=0 in PIN_WAIT or MENU -> IDLE with no eject.
- In EXEC/DONE/STMT the transaction or stream completes first, then IDLE.

day_rollover
- Clears all daily totals in any state.
- If it coincides with an EXEC withdrawal, the check uses the pre-clear total and the total then becomes the amount just withdrawn.

Asynchronous reset mid-session
- Immediately returns to IDLE with reset values, including balances.

Test Plan:
- Insert card, acct 2, pin_ok=1, withdraw 200 -> txn_done 2 cycles after acceptance, status 00, old 1000, new 800; eject on cancel; card_eject held until removal.
- Three pin_entered with pin_ok=0 -> pin_tries 1, 2; card_captured=1 after the third; card_eject stays 0; IDLE after card removal.
- Acct 0: withdraw 300 (ok) then withdraw 300 -> status 10, balance 700; pulse day_rollover, withdraw 300 -> ok, balance 400.
- Withdraw 1200 with balance 1000 -> status 01. Deposit 65000 on balance 1000 (BAL_W=16) -> status 11, balance unchanged.
- Six successful deposits 1..6 on acct 1, then mini-statement -> four beats {10,6},{10,5},{10,4},{10,3}, hist_last on the 4th, then txn_done.
- No input in MENU for TIMEOUT_CYC cycles -> card_eject. Assert reset mid-EXEC -> all outputs 0, balances back to 1000.
